tspi_device: RTL and testbench

SPI-mode-0 target that sits at the far end of the transparent-SPI link and answers the host's byte-framed READ/WRITE/STATUS traffic. It acts as an SD-card stand-in for block-swap bring-up and FPGA loopback. It oversamples the host's SCLK/CS/MOSI in its own clock domain and drives MISO. It also masters a simple byte-wide memory port: fixed one-cycle read latency, no stall.

---
 rtl/tspi_device.sv | 236 +++++++++++++++++++++++
 tb/tb_tspi_device.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tspi_device.sv
// tspi_device: SPI mode-0 target turning host READ(03)/WRITE(02)/STATUS(05) byte traffic into a byte-wide memory port.
// Optional feature macro TSPI_DEVICE_STATUS_EN: adds the STATUS command and the wr_count_last register.
module tspi_device #(
  parameter int AddrBytes = 2,
  localparam int AW = 8 * AddrBytes
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          spi_sclk_i,
  input  logic          spi_cs_ni,
  input  logic          spi_mosi_i,
  output logic          spi_miso_o,
  output logic          spi_miso_oe_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_wdata_o,
  input  logic [7:0]    mem_rdata_i
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, STAT, IGNORE} state_e;

  // [0],[1] synchronise, [2] is the history flop used for edge pulses
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    rx_q, rx_d;
  logic [7:0]    tx_q, tx_d;
  logic          load_pend_q, load_pend_d;
  logic          oe_q, oe_d;
  logic          is_write_q, is_write_d;
  logic [3:0]    ab_cnt_q, ab_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    pf_q, pf_d;
  logic          rd_wait_q, rd_wait_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
`ifdef TSPI_DEVICE_STATUS_EN
  logic [7:0]    wr_cnt_q, wr_cnt_d;
  logic [7:0]    wr_last_q, wr_last_d;
`endif

  logic          sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic [7:0]    rx_byte;
  logic [AW-1:0] addr_shift;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign mosi_s    = mosi_q[1];

  assign spi_miso_o    = tx_q[7];
  assign spi_miso_oe_o = oe_q;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk_i};
      cs_q   <= {cs_q[1:0], spi_cs_ni};
      mosi_q <= {mosi_q[0], spi_mosi_i};
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    load_pend_d = load_pend_q;
    oe_d        = oe_q;
    is_write_d  = is_write_q;
    ab_cnt_d    = ab_cnt_q;
    addr_d      = addr_q;
    pf_d        = rd_wait_q ? mem_rdata_i : pf_q;
    rd_wait_d   = mem_req_q & ~mem_we_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rx_byte     = {rx_q, mosi_s};
    addr_shift  = (addr_q << 8) | AW'(rx_byte);
`ifdef TSPI_DEVICE_STATUS_EN
    wr_cnt_d    = wr_cnt_q;
    wr_last_d   = wr_last_q;
`endif
    // CS rise outranks any coincident SCLK pulse, so a partial byte never reaches memory
    if (cs_rise) begin
      state_d     = IDLE;
      bit_cnt_d   = 3'd0;
      tx_d        = 8'hFF;
      load_pend_d = 1'b0;
      oe_d        = 1'b0;
`ifdef TSPI_DEVICE_STATUS_EN
      if (is_write_q) wr_last_d = wr_cnt_q;
`endif
    end else if (cs_fall) begin
      state_d     = CMD;
      bit_cnt_d   = 3'd0;
      tx_d        = 8'hFF;
      load_pend_d = 1'b0;
      oe_d        = 1'b1;
      is_write_d  = 1'b0;
      ab_cnt_d    = 4'd0;
`ifdef TSPI_DEVICE_STATUS_EN
      wr_cnt_d    = 8'd0;
`endif
    end else if (state_q != IDLE) begin
      if (sclk_fall) begin
        if (load_pend_q) begin
          load_pend_d = 1'b0;
          tx_d        = 8'hFF;
          if (state_q == RDATA) begin
            tx_d       = pf_q;
            mem_req_d  = 1'b1;
            mem_addr_d = addr_q;
            addr_d     = addr_q + AW'(1);
          end
`ifdef TSPI_DEVICE_STATUS_EN
          if (state_q == STAT) tx_d = wr_last_q;
`endif
        end else begin
          tx_d = {tx_q[6:0], 1'b1};
        end
      end
      if (sclk_rise) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          load_pend_d = 1'b1;
          case (state_q)
            CMD: begin
              ab_cnt_d = 4'd0;
              if (rx_byte == 8'h03) begin
                state_d    = ADDR;
                is_write_d = 1'b0;
              end else if (rx_byte == 8'h02) begin
                state_d    = ADDR;
                is_write_d = 1'b1;
`ifdef TSPI_DEVICE_STATUS_EN
              end else if (rx_byte == 8'h05) begin
                state_d = STAT;
`endif
              end else begin
                state_d = IGNORE;
              end
            end
            ADDR: begin
              addr_d = addr_shift;
              if (ab_cnt_q == 4'(AddrBytes - 1)) begin
                if (is_write_q) begin
                  state_d = WDATA;
                end else begin
                  state_d    = DUMMY;
                  mem_req_d  = 1'b1;
                  mem_addr_d = addr_shift;
                end
              end else begin
                ab_cnt_d = ab_cnt_q + 4'd1;
              end
            end
            DUMMY: begin
              state_d = RDATA;
              addr_d  = addr_q + AW'(1);
            end
            WDATA: begin
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_q;
              mem_wdata_d = rx_byte;
              addr_d      = addr_q + AW'(1);
`ifdef TSPI_DEVICE_STATUS_EN
              if (wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'hFF;
      load_pend_q <= 1'b0;
      oe_q        <= 1'b0;
      is_write_q  <= 1'b0;
      ab_cnt_q    <= 4'd0;
      addr_q      <= '0;
      pf_q        <= 8'd0;
      rd_wait_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
`ifdef TSPI_DEVICE_STATUS_EN
      wr_cnt_q    <= 8'd0;
      wr_last_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      load_pend_q <= load_pend_d;
      oe_q        <= oe_d;
      is_write_q  <= is_write_d;
      ab_cnt_q    <= ab_cnt_d;
      addr_q      <= addr_d;
      pf_q        <= pf_d;
      rd_wait_q   <= rd_wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef TSPI_DEVICE_STATUS_EN
      wr_cnt_q    <= wr_cnt_d;
      wr_last_q   <= wr_last_d;
`endif
    end
  end
endmodule

// File: tb/tb_tspi_device.sv
// Bench for tspi_device: host-side SPI driver, behavioural memory, and a transaction-level
// reference model of what every MISO byte and memory access should be.
module tb_tspi_device;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso_o, spi_miso_oe_o;
  logic        mem_req_o, mem_we_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata = 8'd0;

  always #5 clk = ~clk;

  tspi_device #(.AddrBytes(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .spi_sclk_i(spi_sclk), .spi_cs_ni(spi_cs_n), .spi_mosi_i(spi_mosi),
    .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
  );

  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [23:0] wr_log[$];
  logic [15:0] rd_log[$];
  logic [23:0] exp_q[$];
  logic [15:0] exp_rd_q[$];
  logic [7:0]  tx_buf [0:299];
  logic [7:0]  rx_buf [0:299];
  logic        oe_seen;
  logic [7:0]  model_wcl = 8'd0;
  int          total = 0;
  int          bad = 0;

  // memory: read data valid exactly the cycle after the request, junk otherwise
  always @(posedge clk) begin
    if (!rst && mem_req_o && !mem_we_o) mem_rdata <= mem[mem_addr_o];
    else mem_rdata <= 8'($urandom);
    if (!rst && mem_req_o && mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
  end

  always @(negedge clk) begin
    if (!rst && mem_req_o) begin
      if (mem_we_o) wr_log.push_back({mem_addr_o, mem_wdata_o});
      else rd_log.push_back(mem_addr_o);
    end
  end

  function automatic logic [7:0] stat_exp();
`ifdef TSPI_DEVICE_STATUS_EN
    return model_wcl;
`else
    return 8'hFF;
`endif
  endfunction

  // SCLK idles low; each bit = low phase (MOSI set, MISO sampled) then high phase.
  // CS is released while SCLK is still high after the final rise.
  task automatic spi_xfer(input int nbytes, input int nbits, input bit release_cs);
    int nb = nbytes * 8 + nbits;
    spi_cs_n = 1'b0;
    for (int k = 0; k < nb; k++) begin
      if (k != 0) spi_sclk = 1'b0;
      spi_mosi = tx_buf[k / 8][7 - (k % 8)];
      repeat (HALF) @(negedge clk);
      rx_buf[k / 8][7 - (k % 8)] = spi_miso_o;
      if (k == 0) oe_seen = spi_miso_oe_o;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    if (release_cs) begin
      spi_cs_n = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
      repeat (2 * HALF) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    total++; if (spi_miso_o !== 1'b1) begin bad++; $display("FAIL reset_miso: got %b want 1", spi_miso_o); end
    total++; if (spi_miso_oe_o !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
    total++; if (mem_we_o !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", mem_we_o); end
    total++; if (mem_addr_o !== 16'h0000) begin bad++; $display("FAIL reset_addr: got %h want 0000", mem_addr_o); end
    total++; if (mem_wdata_o !== 8'h00) begin bad++; $display("FAIL reset_wdata: got %h want 00", mem_wdata_o); end
  endtask

  task automatic test_write_burst();
    logic [23:0] g, e;
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h10;
    tx_buf[3] = 8'hAA; tx_buf[4] = 8'hBB; tx_buf[5] = 8'hCC;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({16'(16'h0010 + i), tx_buf[3 + i]});
      ref_mem[16'(16'h0010 + i)] = tx_buf[3 + i];
    end
    model_wcl = 8'd3;
    spi_xfer(6, 0, 1'b1);
    total++; if (oe_seen !== 1'b1) begin bad++; $display("FAIL wb_oe_active: got %b want 1", oe_seen); end
    total++; if (spi_miso_oe_o !== 1'b0) begin bad++; $display("FAIL wb_oe_idle: got %b want 0", spi_miso_oe_o); end
    for (int i = 0; i < 6; i++) begin
      total++; if (rx_buf[i] !== 8'hFF) begin bad++; $display("FAIL wb_miso byte %0d: got %h want ff", i, rx_buf[i]); end
    end
    total++; if (wr_log.size() != exp_q.size()) begin bad++; $display("FAIL wb_wcount: got %0d want %0d", wr_log.size(), exp_q.size()); end
    while (wr_log.size() > 0 && exp_q.size() > 0) begin
      g = wr_log.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL wb_write: got %h want %h", g, e); end
    end
    total++; if (rd_log.size() != 0) begin bad++; $display("FAIL wb_reads: got %0d want 0", rd_log.size()); end
    wr_log.delete(); exp_q.delete(); rd_log.delete();
  endtask

  task automatic test_status(input int nfill);
    tx_buf[0] = 8'h05;
    for (int i = 1; i <= nfill; i++) tx_buf[i] = 8'($urandom);
    spi_xfer(1 + nfill, 0, 1'b1);
    total++; if (rx_buf[0] !== 8'hFF) begin bad++; $display("FAIL stat_cmd_byte: got %h want ff", rx_buf[0]); end
    for (int i = 1; i <= nfill; i++) begin
      total++; if (rx_buf[i] !== stat_exp()) begin bad++; $display("FAIL stat_value byte %0d: got %h want %h", i, rx_buf[i], stat_exp()); end
    end
    total++; if (wr_log.size() + rd_log.size() != 0) begin bad++; $display("FAIL stat_mem: got %0d accesses want 0", wr_log.size() + rd_log.size()); end
    wr_log.delete(); rd_log.delete();
  endtask

  // READ at a, ndata data bytes after the dummy: data byte i = mem[a+i], reads at a..a+ndata
  task automatic test_read(input logic [15:0] a, input int ndata, input string tag);
    logic [15:0] g, e;
    tx_buf[0] = 8'h03; tx_buf[1] = a[15:8]; tx_buf[2] = a[7:0];
    for (int i = 3; i < 4 + ndata; i++) tx_buf[i] = 8'($urandom);
    for (int i = 0; i <= ndata; i++) exp_rd_q.push_back(16'(a + i));
    spi_xfer(4 + ndata, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      total++; if (rx_buf[i] !== 8'hFF) begin bad++; $display("FAIL %s_hdr byte %0d: got %h want ff", tag, i, rx_buf[i]); end
    end
    for (int i = 0; i < ndata; i++) begin
      total++; if (rx_buf[4 + i] !== ref_mem[16'(a + i)]) begin bad++; $display("FAIL %s_data byte %0d: got %h want %h", tag, i, rx_buf[4 + i], ref_mem[16'(a + i)]); end
    end
    total++; if (rd_log.size() != exp_rd_q.size()) begin bad++; $display("FAIL %s_rcount: got %0d want %0d", tag, rd_log.size(), exp_rd_q.size()); end
    while (rd_log.size() > 0 && exp_rd_q.size() > 0) begin
      g = rd_log.pop_front(); e = exp_rd_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL %s_raddr: got %h want %h", tag, g, e); end
    end
    total++; if (wr_log.size() != 0) begin bad++; $display("FAIL %s_writes: got %0d want 0", tag, wr_log.size()); end
    wr_log.delete(); rd_log.delete(); exp_rd_q.delete();
  endtask

  task automatic test_abort();
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h20; tx_buf[3] = 8'h5A;
    model_wcl = 8'd0;
    spi_xfer(3, 5, 1'b1);
    total++; if (wr_log.size() != 0) begin bad++; $display("FAIL abort_writes: got %0d want 0", wr_log.size()); end
    total++; if (mem[16'h0020] !== ref_mem[16'h0020]) begin bad++; $display("FAIL abort_mem: got %h want %h", mem[16'h0020], ref_mem[16'h0020]); end
    wr_log.delete(); rd_log.delete();
    test_status(1);
  endtask

  task automatic test_unknown(input logic [7:0] cmd, input int nfill, input int ebits);
    tx_buf[0] = cmd;
    for (int i = 1; i <= nfill; i++) tx_buf[i] = 8'($urandom);
    spi_xfer(1 + nfill, ebits, 1'b1);
    for (int i = 0; i <= nfill; i++) begin
      total++; if (rx_buf[i] !== 8'hFF) begin bad++; $display("FAIL unk_miso cmd %h byte %0d: got %h want ff", cmd, i, rx_buf[i]); end
    end
    total++; if (wr_log.size() + rd_log.size() != 0) begin bad++; $display("FAIL unk_mem cmd %h: got %0d accesses want 0", cmd, wr_log.size() + rd_log.size()); end
    wr_log.delete(); rd_log.delete();
  endtask

  task automatic test_write(input logic [15:0] a, input int n, input int ebits, input string tag);
    logic [23:0] g, e;
    tx_buf[0] = 8'h02; tx_buf[1] = a[15:8]; tx_buf[2] = a[7:0];
    for (int i = 0; i <= n; i++) tx_buf[3 + i] = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({16'(a + i), tx_buf[3 + i]});
      ref_mem[16'(a + i)] = tx_buf[3 + i];
    end
    model_wcl = (n > 255) ? 8'd255 : 8'(n);
    spi_xfer(3 + n, ebits, 1'b1);
    total++; if (wr_log.size() != exp_q.size()) begin bad++; $display("FAIL %s_wcount: got %0d want %0d", tag, wr_log.size(), exp_q.size()); end
    while (wr_log.size() > 0 && exp_q.size() > 0) begin
      g = wr_log.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL %s_write: got %h want %h", tag, g, e); end
    end
    total++; if (rd_log.size() != 0) begin bad++; $display("FAIL %s_reads: got %0d want 0", tag, rd_log.size()); end
    wr_log.delete(); exp_q.delete(); rd_log.delete();
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int kind = $urandom_range(0, 3);
      int n = $urandom_range(1, 5);
      logic [15:0] a = 16'($urandom);
      logic [7:0] c = 8'($urandom);
      if (t % 6 == 0) a = 16'hFFFF - 16'($urandom_range(0, 3));
      case (kind)
        0: test_write(a, n, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0, "rnd_wr");
        1: test_read(a, n, "rnd_rd");
        2: test_status(n);
        default: begin
          if (c == 8'h02 || c == 8'h03 || c == 8'h05) c = 8'h7E;
          test_unknown(c, n, $urandom_range(0, 7));
        end
      endcase
    end
  endtask

  task automatic test_reset_mid();
    mem[16'h0040] = 8'h00; ref_mem[16'h0040] = 8'h00;
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; tx_buf[2] = 8'h40; tx_buf[3] = 8'hFF; tx_buf[4] = 8'hFF;
    spi_xfer(4, 3, 1'b0);
    total++; if (rx_buf[4][7:5] !== ref_mem[16'h0040][7:5]) begin bad++; $display("FAIL rstmid_bits: got %b want %b", rx_buf[4][7:5], ref_mem[16'h0040][7:5]); end
    total++; if (spi_miso_o !== 1'b0) begin bad++; $display("FAIL rstmid_pre_miso: got %b want 0", spi_miso_o); end
    rst = 1'b1;
    #1;
    total++; if (spi_miso_o !== 1'b1) begin bad++; $display("FAIL rstmid_miso: got %b want 1", spi_miso_o); end
    total++; if (spi_miso_oe_o !== 1'b0) begin bad++; $display("FAIL rstmid_oe: got %b want 0", spi_miso_oe_o); end
    spi_cs_n = 1'b1; spi_sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (wr_log.size() != 0) begin bad++; $display("FAIL rstmid_writes: got %0d want 0", wr_log.size()); end
    wr_log.delete(); rd_log.delete();
    model_wcl = 8'd0;
    test_status(2);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    test_write_burst();
    test_status(2);
    test_read(16'h0010, 3, "read");
    test_read(16'hFFFF, 2, "wrap");
    test_abort();
    test_unknown(8'h7E, 3, 0);
    test_random();
    test_write(16'h1000, 257, 0, "sat");
    test_status(2);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
